uart_transmitter_controller: RTL and testbench
==============================================

UART_TRANSMITTER_CONTROLLER -- requirements
Module: uart_transmitter_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: UART frame width; ALU result width is 2*DATA_WIDTH.
REQ-002 The block SHALL have port clk, input, 1: single system clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port alu_out, input, 2*DATA_WIDTH: ALU result.
REQ-005 The block SHALL have port alu_out_valid, input, 1: one-cycle strobe qualifying alu_out.
REQ-006 The block SHALL have port read_data, input, DATA_WIDTH: register-file read result.
REQ-007 The block SHALL have port read_data_valid, input, 1: one-cycle strobe qualifying read_data.
REQ-008 The block SHALL have port tx_busy, input, 1: UART TX busy, already synchronized to clk.
REQ-009 The block SHALL have port tx_data, output, DATA_WIDTH: byte presented to UART TX.
REQ-010 The block SHALL have port tx_data_valid, output, 1: one-cycle send request for tx_data.
REQ-011 The block SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-012 The block SHALL have port response_dropped, output, 1: one-cycle pulse when an incoming response is discarded.

Function
REQ-013 The FSM SHALL have states IDLE, SEND, WAIT_ACCEPT and WAIT_DONE.
REQ-014 In IDLE, on alu_out_valid, the block SHALL capture alu_out into a 2-byte buffer, set byte total to 2, clear byte index and go to SEND.
REQ-015 In IDLE, on read_data_valid alone, the block SHALL capture read_data into buffer byte 0, set byte total to 1 and go to SEND.
REQ-016 If both strobes are high in IDLE, the ALU response SHALL win, and response_dropped SHALL pulse in the next cycle.
REQ-017 In SEND, tx_data_valid SHALL be 1 for exactly one cycle and the FSM SHALL go to WAIT_ACCEPT; a strobe sampled in IDLE at edge N gives tx_data_valid high in cycle N+1.
REQ-018 tx_data SHALL equal the indexed buffer byte from SEND through WAIT_DONE, and 0 in IDLE.
REQ-019 ALU bytes SHALL be sent least-significant byte first.
REQ-020 In WAIT_ACCEPT the FSM SHALL stay until tx_busy=1, then go to WAIT_DONE.
REQ-021 In WAIT_DONE the FSM SHALL stay until tx_busy=0; then, if byte index+1 < total, it SHALL increment the index and go to SEND, otherwise it SHALL go to IDLE.
REQ-022 Any strobe arriving while not in IDLE SHALL be ignored (buffer unchanged), with response_dropped pulsing one cycle later.
REQ-023 A strobe arriving in the same cycle the FSM returns WAIT_DONE->IDLE SHALL be dropped; acceptance requires current state IDLE.
REQ-024 tx_data_valid SHALL never assert while tx_busy=1 is being awaited to fall.

Reset
REQ-025 While reset=1: state=IDLE, buffer=0, index=0, total=0, tx_data=0, tx_data_valid=0, busy=0, response_dropped=0.
REQ-026 Reset mid-frame SHALL abort the response at once with no further tx_data_valid; after release, the block SHALL accept a new strobe on the first clk edge.

Configuration
REQ-027 With macro UART_TX_DROP_COUNTER_EN defined, the block SHALL add output drop_count (8 bits) that increments on every response_dropped pulse, saturates at 255 and resets to 0.
REQ-028 Without UART_TX_DROP_COUNTER_EN, drop_count and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 read_data=0x5A strobe in IDLE, tx_busy rises 2 cycles after tx_data_valid and is held 10 cycles -> exactly one tx_data_valid, tx_data=0x5A, busy returns to 0 the cycle after tx_busy falls.
REQ-030 alu_out=0x1234 strobe -> tx_data_valid with 0x34, then after the busy handshake tx_data_valid with 0x12; exactly two requests.
REQ-031 alu_out_valid and read_data_valid high together (0xBEEF, 0x77) -> bytes 0xEF, 0xBE are sent and response_dropped pulses once.
REQ-032 read_data_valid=0x99 during WAIT_DONE of an ALU frame -> 0x99 is never sent, response_dropped pulses, and (with the macro) drop_count=1.
REQ-033 reset asserted in WAIT_ACCEPT of byte 0 of 0xABCD -> all outputs 0 immediately; after release, a read_data strobe of 0x11 sends 0x11 only.

Source files
------------

// File: rtl/uart_transmitter_controller.sv
// Response serializer: queues an ALU result (2 bytes, LSB first) or a register read (1 byte) for a byte-wide UART TX.
// Optional drop_count output is enabled by defining UART_TX_DROP_COUNTER_EN.
//
//   state       | meaning
//   IDLE        | no response pending, strobes accepted
//   SEND        | one-cycle tx_data_valid request for the indexed byte
//   WAIT_ACCEPT | waiting for the UART to raise tx_busy
//   WAIT_DONE   | waiting for tx_busy to fall, then next byte or IDLE
module uart_transmitter_controller #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_valid,
  input  logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    read_data_valid,
  input  logic                    tx_busy,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_data_valid,
  output logic                    busy,
  output logic                    response_dropped
`ifdef UART_TX_DROP_COUNTER_EN
  ,
  output logic [7:0]              drop_count
`endif
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND        = 2'd1,
    WAIT_ACCEPT = 2'd2,
    WAIT_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] buf_q, buf_d;
  logic                    idx_q, idx_d;
  logic [1:0]              total_q, total_d;
  logic                    drop_q, drop_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= 1'b0;
      total_q <= 2'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      total_q <= total_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    total_d = total_q;
    // Only IDLE accepts; there a simultaneous read strobe loses to the ALU result.
    if (state_q == IDLE) begin
      drop_d = alu_out_valid & read_data_valid;
    end else begin
      drop_d = alu_out_valid | read_data_valid;
    end
    case (state_q)
      IDLE: begin
        if (alu_out_valid) begin
          buf_d   = alu_out;
          total_d = 2'd2;
          idx_d   = 1'b0;
          state_d = SEND;
        end else if (read_data_valid) begin
          buf_d   = {{DATA_WIDTH{1'b0}}, read_data};
          total_d = 2'd1;
          idx_d   = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        state_d = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (({1'b0, idx_q} + 2'd1) < total_q) begin
            idx_d   = 1'b1;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_data_valid    = (state_q == SEND);
  assign busy             = (state_q != IDLE);
  assign response_dropped = drop_q;
  assign tx_data          = !busy ? '0 :
                            idx_q ? buf_q[2*DATA_WIDTH-1:DATA_WIDTH] :
                                    buf_q[DATA_WIDTH-1:0];

`ifdef UART_TX_DROP_COUNTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else if (drop_q && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_transmitter_controller.sv
// Bench for uart_transmitter_controller: directed and random responses against a byte-queue model,
// with the bench acting as the UART TX busy handshake.
module tb_uart_transmitter_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic [7:0]  read_data;
  logic        read_data_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        busy;
  logic        response_dropped;
`ifdef UART_TX_DROP_COUNTER_EN
  logic [7:0]  drop_count;
`endif

  uart_transmitter_controller #(.DATA_WIDTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .alu_out          (alu_out),
    .alu_out_valid    (alu_out_valid),
    .read_data        (read_data),
    .read_data_valid  (read_data_valid),
    .tx_busy          (tx_busy),
    .tx_data          (tx_data),
    .tx_data_valid    (tx_data_valid),
    .busy             (busy),
    .response_dropped (response_dropped)
`ifdef UART_TX_DROP_COUNTER_EN
    ,
    .drop_count       (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sent[$];
  logic [7:0] exp_q[$];
  int drop_seen        = 0;
  int exp_drops        = 0;
  int valid_while_busy = 0;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (tx_data_valid === 1'b1) begin
        sent.push_back(tx_data);
        if (tx_busy === 1'b1) valid_while_busy++;
      end
      if (response_dropped === 1'b1) drop_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits for one send request, then plays the UART: busy after lat cycles, held ~hold cycles.
  task automatic serve_byte(input logic [7:0] exp, input int lat, input int hold,
                            input int inj, input logic [7:0] inj_data, output logic drop_at_send);
    bit found = 1'b0;
    drop_at_send = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (tx_data_valid === 1'b1) found = 1'b1;
      else next_cycle();
    end
    chk("send_seen", 32'(found), 32'd1);
    if (!found) return;
    chk("tx_data_send", 32'(tx_data), 32'(exp));
    drop_at_send = response_dropped;
    for (int i = 0; i < lat; i++) begin
      next_cycle();
      @(negedge clk);
      chk("accept_no_valid", 32'(tx_data_valid), 32'd0);
    end
    next_cycle();
    tx_busy = 1'b1;
    @(negedge clk);
    chk("accept_data", 32'(tx_data), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      if (i == inj) begin
        read_data       = inj_data;
        read_data_valid = 1'b1;
      end
      next_cycle();
      read_data_valid = 1'b0;
      @(negedge clk);
      if (i == inj) chk("drop_pulse", 32'(response_dropped), 32'd1);
      chk("done_no_valid", 32'(tx_data_valid), 32'd0);
    end
    chk("done_data", 32'(tx_data), 32'(exp));
    next_cycle();
    tx_busy = 1'b0;
  endtask

  // One complete response; the model pushes the bytes the response must produce.
  task automatic run_frame(input bit use_alu, input bit both, input logic [15:0] a,
                           input logic [7:0] r, input int lat, input int hold,
                           input int inj, input logic [7:0] inj_data, input bit late);
    logic d0, d1;
    alu_out         = a;
    read_data       = r;
    alu_out_valid   = use_alu;
    read_data_valid = !use_alu || both;
    next_cycle();
    alu_out_valid   = 1'b0;
    read_data_valid = 1'b0;
    if (use_alu) begin
      exp_q.push_back(a[7:0]);
      exp_q.push_back(a[15:8]);
      if (both) exp_drops++;
    end else begin
      exp_q.push_back(r);
    end
    if (inj >= 0) exp_drops++;
    if (late) exp_drops++;
    serve_byte(use_alu ? a[7:0] : r, lat, hold, inj, inj_data, d0);
    chk("drop_at_send", 32'(d0), 32'(use_alu && both));
    if (use_alu) serve_byte(a[15:8], lat, hold, -1, 8'h00, d1);
    @(negedge clk);
    chk("busy_until_fall", 32'(busy), 32'd1);
    if (late) begin
      read_data       = 8'hC3;
      read_data_valid = 1'b1;
    end
    next_cycle();
    read_data_valid = 1'b0;
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("tx_data_idle", 32'(tx_data), 32'd0);
    if (late) chk("late_drop", 32'(response_dropped), 32'd1);
  endtask

  initial begin
    bit          use_alu, both;
    logic [15:0] ra;
    logic [7:0]  rr;
    int          lat, hold, inj;

    reset           = 1'b1;
    alu_out         = '0;
    alu_out_valid   = 1'b0;
    read_data       = '0;
    read_data_valid = 1'b0;
    tx_busy         = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dropped", 32'(response_dropped), 32'd0);
`ifdef UART_TX_DROP_COUNTER_EN
    chk("rst_drop_count", 32'(drop_count), 32'd0);
`endif
    reset = 1'b0;

    run_frame(1'b0, 1'b0, 16'h0000, 8'h5A, 1, 9, -1, 8'h00, 1'b0);
    run_frame(1'b1, 1'b0, 16'h1234, 8'h00, 0, 3, -1, 8'h00, 1'b0);
    run_frame(1'b1, 1'b0, 16'hA5C3, 8'h00, 2, 6, 3, 8'h99, 1'b0);
`ifdef UART_TX_DROP_COUNTER_EN
    chk("drop_count_one", 32'(drop_count), 32'd1);
`endif
    run_frame(1'b1, 1'b1, 16'hBEEF, 8'h77, 1, 2, -1, 8'h00, 1'b0);
    run_frame(1'b0, 1'b0, 16'h0000, 8'h42, 0, 2, -1, 8'h00, 1'b1);

    // Reset while byte 0 of 0xABCD awaits acceptance.
    alu_out       = 16'hABCD;
    alu_out_valid = 1'b1;
    next_cycle();
    alu_out_valid = 1'b0;
    @(negedge clk);
    chk("abcd_valid", 32'(tx_data_valid), 32'd1);
    chk("abcd_byte0", 32'(tx_data), 32'hCD);
    exp_q.push_back(8'hCD);
    next_cycle();
    reset = 1'b1;
    #1;
    chk("abort_tx_data", 32'(tx_data), 32'd0);
    chk("abort_valid", 32'(tx_data_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dropped", 32'(response_dropped), 32'd0);
`ifdef UART_TX_DROP_COUNTER_EN
    chk("abort_drop_count", 32'(drop_count), 32'd0);
`endif
    repeat (3) next_cycle();
    @(negedge clk);
    chk("held_rst_valid", 32'(tx_data_valid), 32'd0);
    reset = 1'b0;
    run_frame(1'b0, 1'b0, 16'h0000, 8'h11, 0, 2, -1, 8'h00, 1'b0);

    for (int k = 0; k < 10; k++) begin
      use_alu = 1'($urandom_range(0, 1));
      both    = use_alu ? 1'($urandom_range(0, 1)) : 1'b0;
      ra      = 16'($urandom);
      rr      = 8'($urandom);
      lat     = int'($urandom_range(0, 3));
      hold    = int'($urandom_range(1, 6));
      inj     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, hold - 1)) : -1;
      run_frame(use_alu, both, ra, rr, lat, hold, inj, 8'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    chk("sent_count", 32'(sent.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
      chk($sformatf("sent_byte_%0d", i), 32'(sent[i]), 32'(exp_q[i]));
    end
    chk("drop_total", 32'(drop_seen), 32'(exp_drops));
    chk("valid_while_busy", 32'(valid_while_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
